// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX-stage controller and alu_seq.
// The requester drives operands; the ALU returns the registered result.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             out_valid;
  logic [WIDTH-1:0] dataOut;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, dataA, dataB, Signal,
    input  in_ready, out_valid, dataOut, zero, overflow
  );

  modport slave (
    input  in_valid, dataA, dataB, Signal,
    output in_ready, out_valid, dataOut, zero, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered MIPS R-type ALU with valid/ready input handshake and a
// WIDTH-cycle shift-add MULTU feeding internal HI/LO registers.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg;
  logic [SHW:0]       count_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   data_out_reg;
  logic               zero_reg;
  logic               overflow_reg;
  logic               out_valid_reg;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_ovf;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;

  assign sum     = bus.dataA + bus.dataB;
  assign diff    = bus.dataA - bus.dataB;
  assign add_ovf = (bus.dataA[WIDTH-1] == bus.dataB[WIDTH-1]) &&
                   (sum[WIDTH-1] != bus.dataA[WIDTH-1]);
  assign sub_ovf = (bus.dataA[WIDTH-1] != bus.dataB[WIDTH-1]) &&
                   (diff[WIDTH-1] != bus.dataA[WIDTH-1]);

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (bus.Signal)
      F_AND:  alu_result = bus.dataA & bus.dataB;
      F_OR:   alu_result = bus.dataA | bus.dataB;
      F_ADD: begin
        alu_result = sum;
        alu_ovf    = add_ovf;
      end
      F_SUB: begin
        alu_result = diff;
        alu_ovf    = sub_ovf;
      end
      // Sign of the difference corrected by overflow gives the true signed order.
      F_SLT:  alu_result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      F_SRL:  alu_result = bus.dataA >> bus.dataB[SHW-1:0];
      F_MFHI: alu_result = hi_reg;
      F_MFLO: alu_result = lo_reg;
      default: begin
        alu_result = '0;
        alu_ovf    = 1'b0;
      end
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half (with carry), then shift the whole product right by one.
  assign step_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                     ({(WIDTH+1){prod_reg[0]}} & {1'b0, mcand_reg});
  assign prod_next = {step_sum, prod_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      mcand_reg     <= '0;
      prod_reg      <= '0;
      data_out_reg  <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.Signal == F_MULTU) begin
              mcand_reg <= bus.dataA;
              prod_reg  <= {{WIDTH{1'b0}}, bus.dataB};
              count_reg <= '0;
              state_reg <= MUL;
            end else begin
              data_out_reg  <= alu_result;
              zero_reg      <= (alu_result == '0);
              overflow_reg  <= alu_ovf;
              out_valid_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          prod_reg  <= prod_next;
          count_reg <= count_reg + (SHW+1)'(1);
          if (count_reg == LAST_STEP) begin
            hi_reg        <= prod_next[2*WIDTH-1:WIDTH];
            lo_reg        <= prod_next[WIDTH-1:0];
            data_out_reg  <= '0;
            zero_reg      <= 1'b1;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.dataOut   = data_out_reg;
  assign bus.zero      = zero_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_alu_seq;
  localparam int WIDTH = 32;

  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state: what the outputs must show in the
  // cycle following each clock edge.
  int          edge_no   = 0;
  int          ready_at  = 0;
  bit          mul_pending = 1'b0;
  int          mul_done  = 0;
  logic [31:0] mul_hi    = '0;
  logic [31:0] mul_lo    = '0;
  logic [31:0] m_hi      = '0;
  logic [31:0] m_lo      = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ready = 1'b1;
  logic [31:0] exp_data  = '0;
  logic        exp_zero  = 1'b0;
  logic        exp_ovf   = 1'b0;

  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 output logic [31:0] r, output logic o);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = '0;
    o  = 1'b0;
    case (f)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD: begin
        s = sa + sb;
        r = s[31:0];
        o = (s > MAX_S) || (s < MIN_S);
      end
      OP_SUB: begin
        s = sa - sb;
        r = s[31:0];
        o = (s > MAX_S) || (s < MIN_S);
      end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SRL:  r = a >> b[4:0];
      OP_MFHI: r = hi;
      OP_MFLO: r = lo;
      default: r = '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] p;
    logic [31:0] r;
    logic        o;
    if (!rst_n) begin
      ready_at    = 0;
      mul_pending = 1'b0;
      m_hi        = '0;
      m_lo        = '0;
      exp_valid   = 1'b0;
      exp_ready   = 1'b1;
      exp_data    = '0;
      exp_zero    = 1'b0;
      exp_ovf     = 1'b0;
    end else begin
      edge_no   = edge_no + 1;
      exp_valid = 1'b0;
      if (mul_pending && edge_no == mul_done) begin
        m_hi        = mul_hi;
        m_lo        = mul_lo;
        mul_pending = 1'b0;
        exp_valid   = 1'b1;
        exp_data    = '0;
        exp_zero    = 1'b1;
        exp_ovf     = 1'b0;
      end
      if (edge_no >= ready_at && bus.in_valid) begin
        if (bus.Signal == OP_MULTU) begin
          p           = {32'b0, bus.dataA} * {32'b0, bus.dataB};
          mul_hi      = p[63:32];
          mul_lo      = p[31:0];
          mul_pending = 1'b1;
          mul_done    = edge_no + WIDTH;
          ready_at    = mul_done + 1;
        end else begin
          ref_op(bus.Signal, bus.dataA, bus.dataB, m_hi, m_lo, r, o);
          exp_valid = 1'b1;
          exp_data  = r;
          exp_zero  = (r == 32'd0);
          exp_ovf   = o;
        end
      end
      exp_ready = (edge_no + 1 >= ready_at);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.Signal   = f;
    bus.dataA    = a;
    bus.dataB    = b;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("txn op=%b A=%h B=%h", f, a, b);
  endtask

  function automatic logic [5:0] pick_op(input int idx);
    case (idx)
      0: return OP_AND;
      1: return OP_OR;
      2: return OP_ADD;
      3: return OP_SUB;
      4: return OP_SLT;
      5: return OP_SRL;
      6: return OP_MULTU;
      7: return OP_MFHI;
      default: return OP_MFLO;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) != 0) return $urandom;
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    int low_cnt;
    int lat;
    logic [5:0] f;
    bit known;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.Signal   = '0;
    bus.dataA    = '0;
    bus.dataB    = '0;

    fork
      forever begin
        @(negedge clk);
        chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, exp_ready});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
        chk("dataOut",   bus.dataOut,            exp_data);
        chk("zero",      {31'b0, bus.zero},      {31'b0, exp_zero});
        chk("overflow",  {31'b0, bus.overflow},  {31'b0, exp_ovf});
      end
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    @(negedge clk);
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_dataOut",   bus.dataOut,            32'd0);
    chk("rst_zero",      {31'b0, bus.zero},      32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD overflow, SUB zero, SLT signed compares
    do_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("add_data",  bus.dataOut,            32'h8000_0000);
    chk("add_ovf",   {31'b0, bus.overflow},  32'd1);
    chk("add_zero",  {31'b0, bus.zero},      32'd0);
    do_op(OP_SUB, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub_data", bus.dataOut,           32'd0);
    chk("sub_zero", {31'b0, bus.zero},     32'd1);
    chk("sub_ovf",  {31'b0, bus.overflow}, 32'd0);
    do_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    chk("slt_neg", bus.dataOut, 32'd1);
    do_op(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
    @(negedge clk);
    chk("slt_ovf", bus.dataOut, 32'd1);

    // MULTU timing and HI/LO
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    low_cnt = 0;
    lat     = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.in_ready) low_cnt++;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    chk("mul_ready_low", low_cnt, 32'd32);
    chk("mul_latency",   lat,     32'd33);
    do_op(OP_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("mfhi_data", bus.dataOut, 32'hFFFF_FFFE);
    do_op(OP_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("mflo_data", bus.dataOut, 32'h0000_0001);

    // Four back-to-back single-cycle ops
    do_op(OP_ADD, 32'd1, 32'd2);
    do_op(OP_OR,  32'h0000_00F0, 32'h0000_000F);
    do_op(OP_AND, 32'h0000_FF00, 32'h0000_0FF0);
    do_op(OP_SRL, 32'h8000_0000, 32'd31);
    @(negedge clk);
    chk("srl_data",  bus.dataOut,            32'h0000_0001);
    chk("srl_valid", {31'b0, bus.out_valid}, 32'd1);

    // Reset pulsed mid-MULTU
    do_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(OP_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("midrst_mflo", bus.dataOut, 32'd0);

    // Undefined function code leaves HI/LO untouched
    do_op(OP_MULTU, 32'h0001_0000, 32'h0003_0003);
    do_op(6'b111111, 32'hDEAD_BEEF, 32'h7FFF_FFFF);
    @(negedge clk);
    chk("bad_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bad_data",  bus.dataOut,            32'd0);
    chk("bad_ovf",   {31'b0, bus.overflow},  32'd0);
    do_op(OP_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("bad_hi", bus.dataOut, 32'h0000_0003);
    do_op(OP_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("bad_lo", bus.dataOut, 32'h0003_0000);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do begin
          f     = 6'($urandom);
          known = 1'b0;
          for (int k = 0; k < 9; k++) if (pick_op(k) == f) known = 1'b1;
        end while (known);
      end else begin
        f = pick_op($urandom_range(0, 8));
      end
      do_op(f, pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 32-bit combinational MIPS ALU. Executes the existing R-type functions (AND, OR, ADD, SUB, SLT) plus SRL, MULTU, MFHI and MFLO over a WIDTH-bit datapath. A valid/ready input handshake lets it sit in the EX stage of the multi-cycle datapath. MULTU runs as a WIDTH-cycle shift-add sequence into internal HI/LO registers.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 4
- SHW, log2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- dataA  in  WIDTH  operand A
- dataB  in  WIDTH  operand B; for SRL, shift amount is dataB[SHW-1:0]
- Signal  in  6  function code
- out_valid  out  1  one-cycle pulse: result registers updated
- dataOut  out  WIDTH  registered result
- zero  out  1  registered; dataOut == 0
- overflow  out  1  registered; signed overflow of ADD/SUB, else 0

## Operation
- Function codes:
  - AND 100100
  - OR 100101
  - ADD 100000
  - SUB 100010
  - SLT 101010: signed compare, result 1 or 0 zero-extended
  - SRL 000010: logical right shift of dataA
  - MULTU 011001
  - MFHI 010000
  - MFLO 010010
  - Any other code: dataOut = 0, overflow = 0, out_valid still pulses.
- Accept occurs on an edge where in_valid && in_ready. Operands and Signal are sampled on that edge only.
- ADD/SUB use modulo-2^WIDTH arithmetic. Overflow is set when the operand signs (B inverted for SUB) are equal and the result sign differs.
- SLT uses the true signed comparison: sign of the difference XOR overflow.
- FSM states are IDLE and MUL.
  - IDLE, accept non-MULTU: compute, load dataOut/zero/overflow, set out_valid. State stays IDLE.
  - IDLE, accept MULTU: latch multiplicand, clear the 2·WIDTH-bit product register with the multiplier in its low half, set count = 0, go to MUL. out_valid = 0.
  - MUL: each edge performs one unsigned shift-add step and increments count.
  - MUL, on the edge completing step WIDTH: write HI = product[2W-1:W] and LO = product[W-1:0], load dataOut = 0, zero = 1, overflow = 0, set out_valid, go to IDLE.
- MFHI/MFLO return the HI/LO contents as they stand at the accept edge.
- HI/LO change only on MULTU completion or reset.

## Timing
- Reset (asynchronous, while low):
  - state = IDLE, count = 0, HI = LO = 0
  - dataOut = 0, zero = 0, overflow = 0, out_valid = 0
  - in_ready = 1
- Single-cycle ops: accept on edge e. out_valid is high in the cycle after e. Latency is 1.
- Back-to-back non-MULTU accepts every cycle are legal; out_valid then stays high continuously.
- MULTU: accept on edge e. in_ready goes low after e and stays low through edge e+WIDTH. out_valid is high in the cycle after e+WIDTH. in_ready = 1 again in that same cycle.
- While in MUL, in_valid is ignored. The requester must hold the request until in_ready is seen.
- MFHI accepted in the first IDLE cycle after MULTU completion returns the new HI.
- Reset mid-MUL: the operation aborts, no out_valid pulse occurs, and HI/LO = 0.
- Reset deasserted between edges: the first accept is possible on the next edge.
- out_valid and in_ready never depend combinationally on in_valid.

## Test plan
All scenarios use WIDTH = 32.
- Reset, then ADD A=0x7FFFFFFF B=0x00000001 → next cycle: out_valid=1, dataOut=0x80000000, overflow=1, zero=0.
- SUB 5−5 → dataOut=0, zero=1, overflow=0. Then SLT A=0xFFFFFFFF B=0x00000001 → dataOut=1. Then SLT A=0x80000000 B=0x7FFFFFFF → dataOut=1.
- MULTU A=B=0xFFFFFFFF with in_valid held → in_ready low for 32 cycles; out_valid in the 33rd cycle after accept. Then MFHI → 0xFFFFFFFE and MFLO → 0x00000001.
- ADD, OR, AND, SRL accepted on four consecutive edges → out_valid high for four consecutive cycles with correct per-op results. SRL A=0x80000000 B=31 → 0x00000001.
- Reset pulsed 10 cycles into a MULTU → out_valid stays 0, in_ready=1 after reset; a following MFLO → 0.
- Signal=111111 → out_valid=1, dataOut=0, overflow=0. HI/LO unchanged from before the op.
